// File: rtl/sha256_round_sched.sv
// sha256_round_sched: collects a 512-bit block, expands W_t on the fly and
// sequences the external compression datapath through init, rounds and update.
module sha256_round_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    input  logic        last_blk_i,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        init_o,
    output logic        first_o,
    output logic        round_en_o,
    output logic [5:0]  t_o,
    output logic [31:0] wt_o,
    output logic        update_o,
    output logic        done_o
);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, UPDATE, DONE} state_t;
    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);
    state_t      state;
    logic [31:0] w [16];
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic        first_q;
    logic        last_q;
    logic        ovf_q;
    logic [31:0] w_next;
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
    // w[0] always holds W_t; w[15] receives W_{t+16} as the window slides
    assign w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            t       <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            if (word_valid_i && busy_o) ovf_q <= 1'b1;
            case (state)
                IDLE, LOAD: if (word_valid_i) begin
                    w[cnt] <= word_i;
                    cnt    <= cnt + 4'd1;
                    state  <= (cnt == 4'd15) ? INIT : LOAD;
                    if (cnt == 4'd15) last_q <= last_blk_i;
                end
                INIT: begin
                    t     <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_next;
                    t     <= t + 6'd1;
                    if (t == T_LAST) state <= UPDATE;
                end
                UPDATE: begin
                    first_q <= last_q;
                    cnt     <= '0;
                    state   <= last_q ? DONE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy_o     = (state == INIT) || (state == ROUND) || (state == UPDATE) || (state == DONE);
    assign overflow_o = ovf_q;
    assign init_o     = state == INIT;
    assign first_o    = first_q;
    assign round_en_o = state == ROUND;
    assign t_o        = round_en_o ? t : '0;
    assign wt_o       = round_en_o ? w[0] : '0;
    assign update_o   = state == UPDATE;
    assign done_o     = state == DONE;
endmodule

// File: tb/tb_sha256_round_sched.sv
// tb_sha256_round_sched: table-driven block runs with a W_t scoreboard,
// plus hand-written overflow and mid-round reset sequences.
module tb_sha256_round_sched;
    localparam int R = 64;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        word_valid_i = 1'b0;
    logic [31:0] word_i = '0;
    logic        last_blk_i = 1'b0;
    logic        busy_o, overflow_o, init_o, first_o, round_en_o, update_o, done_o;
    logic [5:0]  t_o;
    logic [31:0] wt_o;

    sha256_round_sched #(.ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .word_valid_i(word_valid_i), .word_i(word_i),
        .last_blk_i(last_blk_i), .busy_o(busy_o), .overflow_o(overflow_o),
        .init_o(init_o), .first_o(first_o), .round_en_o(round_en_o), .t_o(t_o),
        .wt_o(wt_o), .update_o(update_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    typedef struct packed {logic [5:0] t; logic [31:0] wt;} exp_t;
    exp_t sb[$];
    logic [31:0] seen [R];

    typedef struct {
        int seed;
        bit last;
        bit gap;
        bit exp_first;
        bit exp_done;
        int ovf_t;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    function automatic void gen(input int seed, output logic [31:0] m [16]);
        logic [31:0] x;
        x = 32'(seed) * 32'h9E3779B9;
        for (int i = 0; i < 16; i++) begin
            x = x * 32'd1664525 + 32'd1013904223;
            m[i] = (seed == 0) ? 32'h0 : x;
        end
        if (seed == 0) begin
            m[0] = 32'h61626380;
            m[15] = 32'h00000018;
        end
    endfunction

    function automatic void sched(input logic [31:0] m [16], output logic [31:0] ws [64]);
        for (int i = 0; i < 16; i++) ws[i] = m[i];
        for (int i = 16; i < 64; i++) ws[i] = s1(ws[i-2]) + ws[i-7] + s0(ws[i-15]) + ws[i-16];
    endfunction

    // Scoreboard consumer: every round cycle must match the next expected W_t
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (round_en_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: round t=%0d wt=%0h with no expected entry", t_o, wt_o);
                end else begin
                    e = sb.pop_front();
                    chk("wt", {26'b0, t_o, wt_o}, {26'b0, e.t, e.wt});
                end
                seen[t_o] = wt_o;
            end else begin
                chk("idle_zero", {26'b0, t_o, wt_o}, 64'h0);
            end
        end
    end

    task automatic drive_block(input int seed, input bit last, input bit gap);
        logic [31:0] m [16];
        logic [31:0] ws [64];
        gen(seed, m);
        sched(m, ws);
        for (int i = 0; i < R; i++) sb.push_back('{t: 6'(i), wt: ws[i]});
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            word_valid_i = 1'b1;
            word_i = m[k];
            last_blk_i = last;
            if (gap && k < 15) begin
                @(negedge clk);
                word_valid_i = 1'b0;
            end
        end
    endtask

    task automatic run_block(input vec_t v);
        drive_block(v.seed, v.last, v.gap);
        @(negedge clk);
        word_valid_i = 1'b0;
        last_blk_i = 1'b0;
        chk("init", init_o, 1);
        chk("first", first_o, v.exp_first);
        chk("busy", busy_o, 1);
        for (int i = 0; i < R; i++) begin
            @(negedge clk);
            chk("round_en", round_en_o, 1);
            word_valid_i = (i == v.ovf_t);
            word_i = (i == v.ovf_t) ? 32'hDEADBEEF : 32'h0;
        end
        @(negedge clk);
        word_valid_i = 1'b0;
        chk("update", update_o, 1);
        chk("round_en_off", round_en_o, 0);
        @(negedge clk);
        chk("done", done_o, v.exp_done);
        chk("busy_after_update", busy_o, v.exp_done);
        if (v.exp_done) begin
            @(negedge clk);
            chk("busy_fall", busy_o, 0);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        bit found;
        vecs[0] = '{seed: 0, last: 1, gap: 0, exp_first: 1, exp_done: 1, ovf_t: -1};
        vecs[1] = '{seed: 1, last: 0, gap: 0, exp_first: 1, exp_done: 0, ovf_t: -1};
        vecs[2] = '{seed: 2, last: 1, gap: 0, exp_first: 0, exp_done: 1, ovf_t: -1};
        vecs[3] = '{seed: 3, last: 1, gap: 0, exp_first: 1, exp_done: 1, ovf_t: -1};
        vecs[4] = '{seed: 0, last: 1, gap: 1, exp_first: 1, exp_done: 1, ovf_t: -1};
        vecs[5] = '{seed: 0, last: 1, gap: 0, exp_first: 1, exp_done: 1, ovf_t: 5};
        vecs[6] = '{seed: 4, last: 1, gap: 0, exp_first: 1, exp_done: 1, ovf_t: -1};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_first", first_o, 1);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_pulses", {init_o, update_o, done_o, round_en_o}, 0);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("quiet", {busy_o, init_o, update_o, done_o, round_en_o, overflow_o}, 0);
        end

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < R; j++) seen[j] = 32'hx;
            run_block(vecs[i]);
            chk("overflow", overflow_o, (i >= 5) ? 1 : 0);
            if (vecs[i].seed == 0) begin
                chk("abc_w0", seen[0], 32'h61626380);
                chk("abc_w15", seen[15], 32'h00000018);
                chk("abc_w16", seen[16], 32'h61626380);
                chk("abc_w17", seen[17], 32'h000F0000);
            end
        end

        // Clear first flag, then reset in the middle of the next block
        run_block('{seed: 5, last: 0, gap: 0, exp_first: 1, exp_done: 0, ovf_t: -1});
        chk("first_cleared", first_o, 0);
        drive_block(6, 1'b1, 1'b0);
        @(negedge clk);
        word_valid_i = 1'b0;
        last_blk_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = round_en_o && (t_o == 6'd30);
        end
        chk("reach_t30", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_round", {round_en_o, t_o, wt_o}, 0);
        chk("arst_first", first_o, 1);
        chk("arst_overflow", overflow_o, 0);
        chk("arst_pulses", {init_o, update_o, done_o}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        run_block('{seed: 7, last: 1, gap: 0, exp_first: 1, exp_done: 1, ovf_t: -1});
        chk("post_rst_overflow", overflow_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha256_round_sched.md
Name: sha256_round_sched

Overview:
- Controller between the message preprocessor and the SHA-256 compression datapath.
- Collects the 16-word (512-bit) block streamed by the preprocessor as valid-qualified 32-bit words.
- Expands the block on the fly into the message schedule W_t.
- Sequences the external round datapath through init, ROUNDS round cycles and the hash update, and tracks first/last block of a multi-block message.

Parameters:
- ROUNDS, 64, number of compression rounds per block; legal range 16..64, 64 for compliant SHA-256.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- word_valid_i  input  1  word_i valid this cycle
- word_i  input  32  message word, big-endian, word 0 of the block first
- last_blk_i  input  1  sampled with the 16th word; 1 = final block of the message
- busy_o  output  1  block captured and not yet released; upstream must hold words
- overflow_o  output  1  sticky; a word arrived while busy_o=1
- init_o  output  1  one-cycle pulse: load working vars a..h from H
- first_o  output  1  valid with init_o; 1 = load H from the IV rather than the stored hash
- round_en_o  output  1  round datapath executes round t_o this cycle
- t_o  output  6  round index
- wt_o  output  32  W_t for round t_o
- update_o  output  1  one-cycle pulse: H <= H + a..h
- done_o  output  1  one-cycle pulse: digest final after a last block

Behaviour:
- Reset (rst=0, async): state=IDLE, word count=0, first flag=1, schedule window cleared. All outputs 0, except first_o=1.
- States: IDLE, LOAD, INIT, ROUND, UPDATE, DONE.
- IDLE/LOAD, word capture:
  - Each word_valid_i=1 writes word_i into window slot cnt, then cnt++.
  - The first word moves IDLE->LOAD.
  - On the 16th word (cnt=15): last_blk_i is latched and state->INIT.
  - Gaps (word_valid_i=0) are allowed and hold cnt.
- INIT: 1 cycle. init_o=1; first_o = first flag. ->ROUND with t=0.
- ROUND: ROUNDS cycles.
  - round_en_o=1, t_o=t, wt_o=w[0].
  - Each cycle the window shifts: w[i]<=w[i+1] for i<15, and w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0] mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t=ROUNDS-1 -> UPDATE.
- UPDATE: 1 cycle. update_o=1; first flag <= latched last.
  - If last: ->DONE.
  - Else: ->IDLE, cnt=0.
- DONE: 1 cycle. done_o=1; ->IDLE.
- Latency: 16th word captured at edge E0. Then:
  - init_o in cycle E0+1.
  - rounds t=0..ROUNDS-1 in cycles E0+2..E0+ROUNDS+1.
  - update_o at E0+ROUNDS+2.
  - done_o at E0+ROUNDS+3.
- busy_o=1 in INIT, ROUND, UPDATE, DONE; 0 in IDLE/LOAD. It is registered, so it rises the cycle after the 16th word.
- word_valid_i=1 while busy_o=1: the word is dropped, overflow_o<=1, and the sequence is unaffected. overflow_o clears only on reset.
- A word in the cycle busy_o falls (IDLE entry) is accepted as word 0 of the next block.
- wt_o, t_o are 0 whenever round_en_o=0.
- Reset mid-operation: immediate return to the reset state. Any partial block and the latched last flag are discarded.

Test Plan:
- Reset values: hold rst=0 -> busy_o=0, first_o=1, overflow_o=0, and all pulses 0. Release reset, then idle 10 cycles -> no output activity.
- "abc" block: feed 0x61626380, 14x 0x00000000, 0x00000018 back-to-back with last_blk_i=1 ->
  - init_o with first_o=1 one cycle after the 16th word.
  - wt_o = 0x61626380 at t=0, 0x00000018 at t=15, 0x61626380 at t=16, 0x000F0000 at t=17.
  - update_o at E0+66, done_o at E0+67.
- Two-block message: block A with last=0, then block B with last=1 -> block A: update_o but no done_o. Block B: init_o with first_o=0, then done_o. A third block afterwards gets first_o=1.
- Gapped input: 16 words with word_valid_i toggled 1,0,1,0 -> identical wt_o sequence to the back-to-back case; init_o 1 cycle after the last word.
- Overflow: assert word_valid_i with 0xDEADBEEF at t=5 of ROUND -> overflow_o=1 and stays 1. wt_o sequence unchanged; cnt still 0 in IDLE.
- Reset mid-ROUND (t=30): pulse rst low -> all outputs drop to reset values asynchronously. A new full block then sequences normally with first_o=1.
